complex_to_pixel: RTL

- Inverse of the pixel-to-complex mapper. Takes a Q(16-FRAC).FRAC complex point and returns the screen pixel (x, y) that contains it, plus an in-view flag.
- Used to plot orbit points, cursor markers and pan/zoom anchors back onto the 640x480 frame.
- Division is a multi-cycle restoring divider, with valid/ready handshakes on the input and output sides.

---
 rtl/complex_to_pixel.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/complex_to_pixel.sv
// complex_to_pixel: maps a Q(16-FRAC).FRAC complex point to its 640x480 screen pixel.
// Two parallel multi-cycle restoring dividers (one quotient bit per cycle, MSB first)
// convert the offset from the view origin into column/row, with valid/ready on both sides.
// Optional build macro C2P_CLAMP_EN: out-of-range axes clamp to the nearest screen edge
// instead of reporting 0. in_view is 0 for any out-of-range axis in both builds.
module complex_to_pixel #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAC          = 8,
    parameter int REAL_MIN      = -(2 <<< FRAC),
    parameter int REAL_WIDTH    = 3 <<< FRAC,
    parameter int IMAG_MAX      = 2 <<< FRAC,
    parameter int IMAG_HEIGHT   = 4 <<< FRAC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] real_part,
    input  logic [15:0] im_part,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        in_view
);

    localparam int unsigned CW   = 16;  // coordinate width
    localparam int unsigned DW   = 17;  // signed offset width
    localparam int unsigned NW   = 27;  // dividend / remainder width
    localparam int unsigned XW   = 10;  // x quotient width
    localparam int unsigned YW   = 9;   // y quotient width
    localparam int unsigned CNTW = 4;
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(9);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [CW-1:0]   real_q, real_n;
    logic [CW-1:0]   im_q, im_n;
    logic            x_lo, x_lo_n, x_hi, x_hi_n;
    logic            y_lo, y_lo_n, y_hi, y_hi_n;
    logic [NW-1:0]   rem_x, rem_x_n, rem_y, rem_y_n;
    logic [XW-2:0]   q_x, q_x_n;
    logic [YW-2:0]   q_y, q_y_n;
    logic            in_ready_n, out_valid_n, in_view_n;
    logic [XW-1:0]   x_n;
    logic [YW-1:0]   y_n;

    // Combinational helpers
    logic [DW-1:0]   dx, dy;
    logic [NW-1:0]   dsh_x, dsh_y;
    logic            fit_x, fit_y;
    logic [XW-1:0]   q_x_step, x_res;
    logic [YW-1:0]   q_y_step, y_res;

    // State and output registers; reset drops any in-flight point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            real_q    <= '0;
            im_q      <= '0;
            x_lo      <= 1'b0;
            x_hi      <= 1'b0;
            y_lo      <= 1'b0;
            y_hi      <= 1'b0;
            rem_x     <= '0;
            rem_y     <= '0;
            q_x       <= '0;
            q_y       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
            in_view   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            real_q    <= real_n;
            im_q      <= im_n;
            x_lo      <= x_lo_n;
            x_hi      <= x_hi_n;
            y_lo      <= y_lo_n;
            y_hi      <= y_hi_n;
            rem_x     <= rem_x_n;
            rem_y     <= rem_y_n;
            q_x       <= q_x_n;
            q_y       <= q_y_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            x         <= x_n;
            y         <= y_n;
            in_view   <= in_view_n;
        end
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        real_n   = real_q;
        im_n     = im_q;
        x_lo_n   = x_lo;
        x_hi_n   = x_hi;
        y_lo_n   = y_lo;
        y_hi_n   = y_hi;
        rem_x_n  = rem_x;
        rem_y_n  = rem_y;
        q_x_n    = q_x;
        q_y_n    = q_y;
        x_n      = x;
        y_n      = y;
        in_view_n = in_view;

        // Offsets from the top-left corner of the view, sign-extended to 17 bits
        dx = {real_q[CW-1], real_q} - DW'(REAL_MIN);
        dy = DW'(IMAG_MAX) - {im_q[CW-1], im_q};

        // Divisor aligned to the quotient bit being resolved this cycle
        dsh_x = NW'(REAL_WIDTH)  << (LAST_BIT - cnt);
        dsh_y = NW'(IMAG_HEIGHT) << (LAST_BIT - cnt);
        fit_x = (rem_x >= dsh_x);
        fit_y = (rem_y >= dsh_y);
        q_x_step = {q_x, fit_x};
        q_y_step = {q_y, fit_y};

`ifdef C2P_CLAMP_EN
        x_res = x_hi ? XW'(SCREEN_WIDTH - 1)  : (x_lo ? '0 : q_x_step);
        y_res = y_hi ? YW'(SCREEN_HEIGHT - 1) : (y_lo ? '0 : q_y_step);
`else
        x_res = (x_lo || x_hi) ? '0 : q_x_step;
        y_res = (y_lo || y_hi) ? '0 : q_y_step;
`endif

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    real_n  = real_part;
                    im_n    = im_part;
                    state_n = PREP;
                end
            end
            PREP: begin
                x_lo_n  = dx[DW-1];
                x_hi_n  = !dx[DW-1] && (dx >= DW'(REAL_WIDTH));
                y_lo_n  = dy[DW-1];
                y_hi_n  = !dy[DW-1] && (dy >= DW'(IMAG_HEIGHT));
                rem_x_n = (x_lo_n || x_hi_n) ? '0 : NW'(NW'(dx) * NW'(SCREEN_WIDTH));
                rem_y_n = (y_lo_n || y_hi_n) ? '0 : NW'(NW'(dy) * NW'(SCREEN_HEIGHT));
                q_x_n   = '0;
                q_y_n   = '0;
                cnt_n   = '0;
                state_n = DIV;
            end
            DIV: begin
                if (fit_x) rem_x_n = rem_x - dsh_x;
                if (fit_y) rem_y_n = rem_y - dsh_y;
                q_x_n = q_x_step[XW-2:0];
                q_y_n = q_y_step[YW-2:0];
                cnt_n = cnt + CNTW'(1);
                if (cnt == LAST_BIT) begin
                    cnt_n     = '0;
                    x_n       = x_res;
                    y_n       = y_res;
                    in_view_n = !(x_lo || x_hi || y_lo || y_hi);
                    state_n   = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
    end

endmodule
